// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// Program sequencer: small instruction store issuing one 9-bit func word per clock.
// Latency: first instruction on func the cycle after start; N instructions take N RUN cycles, done in cycle N+1.
// Backpressure: load-type instructions stall issue (func=IDLE_FUNC, dataReq=1) until dataValid; stalls are unbounded.
module instr_sequencer #(
  parameter int         PROG_DEPTH = 16,           // must equal 2**ADDR_W
  parameter int         ADDR_W     = 4,
  parameter logic [2:0] LOAD_OP    = 3'b000,
  parameter logic [8:0] IDLE_FUNC  = 9'b011_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [8:0]        loadInstr,
  input  logic [ADDR_W-1:0] lastAddr,
  input  logic              start,
  input  logic              abort,
  input  logic              dataValid,
  output logic [8:0]        func,
  output logic              dataReq,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   issueCnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [8:0]        mem [PROG_DEPTH];
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] last_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [8:0]        cur;
  logic              is_load;
  logic              issue;

  // Asynchronous read of the instruction addressed by pc.
  assign cur     = mem[pc];
  assign is_load = (cur[8:6] == LOAD_OP);
  assign issue   = !is_load || dataValid;

  // Instruction store: writable only while no program is running; never cleared by reset.
  always_ff @(posedge clock) begin
    if (loadEn && (state != S_RUN)) begin
      mem[loadAddr] <= loadInstr;
    end
  end

  // State, program counter, issue counter and latched last address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      issueCnt  <= '0;
      last_addr <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      issueCnt  <= cnt_nxt;
      last_addr <= last_nxt;
    end
  end

  // Next-state and output decode; abort outranks issue, a stall holds pc and count.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = issueCnt;
    last_nxt  = last_addr;
    func      = IDLE_FUNC;
    dataReq   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          last_nxt  = lastAddr;
          pc_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        dataReq = is_load && !dataValid;
        if (issue) begin
          func = cur;
        end
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (issue) begin
          cnt_nxt = issueCnt + 1'b1;
          if (pc == last_addr) begin
            state_nxt = S_DONE;
          end else begin
            pc_nxt = pc + 1'b1;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
